// File: rtl/afifo_byte_packer.sv
// Read-side consumer for the async FIFO: pops 12-bit words in pairs and emits
// each pair as three bytes on a valid/ready stream; flush drains an odd word.
module afifo_byte_packer #(
  parameter int CountWidth = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  output logic                  fifo_r,
  input  logic [11:0]           fifo_rd,
  input  logic                  fifo_rempty,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last,
  output logic [CountWidth-1:0] byte_count
);

  typedef enum logic [2:0] {S_A, S_B, S_BYTE0, S_BYTE1, S_BYTE2} state_e;

  state_e                state_q, state_d;
  logic [11:0]           a_q, a_d, b_q, b_d;
  logic                  pad_q, pad_d;
  logic                  fp_q, fp_d;
  logic                  fd_q, fd_d;
  logic [CountWidth-1:0] cnt_q, cnt_d;
  logic                  pop, beat, fp_clr;

  // Pop request depends only on state and reset, never on empty or ready.
  assign fifo_r = ((state_q == S_A) || (state_q == S_B)) && !rrst;
  assign pop    = fifo_r && !fifo_rempty;

  assign out_valid  = (state_q == S_BYTE0) || (state_q == S_BYTE1) ||
                      (state_q == S_BYTE2);
  assign beat       = out_valid && out_ready;
  assign out_last   = (state_q == S_BYTE1) && pad_q;
  assign flush_done = fd_q;
  assign byte_count = cnt_q;

  always_comb begin
    out_data = 8'h00;
    case (state_q)
      S_BYTE0: out_data = a_q[7:0];
      S_BYTE1: out_data = {b_q[3:0], a_q[11:8]};
      S_BYTE2: out_data = b_q[11:4];
      default: out_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    pad_d   = pad_q;
    fd_d    = 1'b0;
    fp_clr  = 1'b0;
    case (state_q)
      S_A: begin
        if (pop) begin
          a_d     = fifo_rd;
          state_d = S_B;
        end else if (fp_q && fifo_rempty) begin
          fp_clr = 1'b1;
          fd_d   = 1'b1;
        end
      end
      S_B: begin
        if (pop) begin
          b_d     = fifo_rd;
          pad_d   = 1'b0;
          state_d = S_BYTE0;
        end else if (fp_q && fifo_rempty) begin
          b_d     = 12'h000;
          pad_d   = 1'b1;
          fp_clr  = 1'b1;
          state_d = S_BYTE0;
        end
      end
      S_BYTE0: if (beat) state_d = S_BYTE1;
      S_BYTE1: begin
        if (beat) begin
          state_d = pad_q ? S_A : S_BYTE2;
          fd_d    = pad_q;
        end
      end
      S_BYTE2: if (beat) state_d = S_A;
      default: state_d = S_A;
    endcase
  end

  // A new flush request wins over a clear on the same edge.
  assign fp_d  = flush | (fp_q & ~fp_clr);
  assign cnt_d = beat ? cnt_q + CountWidth'(1) : cnt_q;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q <= S_A;
      a_q     <= 12'h000;
      b_q     <= 12'h000;
      pad_q   <= 1'b0;
      fp_q    <= 1'b0;
      fd_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pad_q   <= pad_d;
      fp_q    <= fp_d;
      fd_q    <= fd_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
